// File: rtl/mda_pixel_serializer.sv
// MDA dot serializer: turns one character cell (font row, attribute, qualifiers)
// into 9 registered video/intensity dots, applying the MDA attribute rules.
module mda_pixel_serializer #(
  parameter int BLINK_BIT  = 4,
  parameter int CURSOR_BIT = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dot_en,
  input  logic       load,
  input  logic [7:0] char_row,
  input  logic [7:0] char_code,
  input  logic [7:0] attr,
  input  logic       cursor,
  input  logic       underline_row,
  input  logic       display_enable,
  input  logic       blink_enable,
  input  logic       vsync,
  output logic       video,
  output logic       intensity,
  output logic [4:0] frame_cnt
);

  localparam logic [3:0] DOT_LAST = 4'd8;
  localparam logic [3:0] DOT_IDLE = 4'd9;

  logic       vsync_q, vsync_d;
  logic [4:0] frame_cnt_q, frame_cnt_d;
  logic [8:0] shift_q, shift_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] attr_q, attr_d;
  logic       cur_q, cur_d;
  logic       ul_q, ul_d;
  logic       de_q, de_d;
  logic       video_q, video_d;
  logic       intensity_q, intensity_d;
  logic       line_gfx;
  logic [1:0] dot_out;

  // Returns {video, intensity} for one dot; first matching rule wins.
  function automatic logic [1:0] decode_dot(
    input logic       de,
    input logic       cur,
    input logic       ul,
    input logic [7:0] a,
    input logic       d,
    input logic       blink_en,
    input logic       blink_off,
    input logic       cursor_on
  );
    logic fg;
    logic [1:0] res;
    fg = d | (ul && (a[2:0] == 3'b001));
    if (blink_en && a[7] && blink_off) fg = 1'b0;
    if (!de)                               res = 2'b00;
    else if (cur && cursor_on)             res = {1'b1, a[3]};
    else if ((a & 8'h77) == 8'h00)         res = 2'b00;
    else if ((a & 8'h77) == 8'h70)         res = {~fg, ~blink_en & a[7] & ~fg};
    else                                   res = {fg, fg & a[3]};
    return res;
  endfunction

  always_comb begin
    vsync_d     = vsync;
    frame_cnt_d = frame_cnt_q + {4'b0000, vsync & ~vsync_q};
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    attr_d      = attr_q;
    cur_d       = cur_q;
    ul_d        = ul_q;
    de_d        = de_q;
    video_d     = video_q;
    intensity_d = intensity_q;
    line_gfx    = (char_code[7:5] == 3'b110);
    dot_out     = 2'b00;

    if (dot_en) begin
      if (load) begin
        attr_d  = attr;
        cur_d   = cursor;
        ul_d    = underline_row;
        de_d    = display_enable;
        shift_d = {char_row, line_gfx & char_row[0]};
        cnt_d   = 4'd0;
        // Dot 0 is decoded from the incoming cell, not the old latched one.
        dot_out = decode_dot(display_enable, cursor, underline_row, attr, char_row[7],
                             blink_enable, frame_cnt_q[BLINK_BIT], frame_cnt_q[CURSOR_BIT]);
        video_d     = dot_out[1];
        intensity_d = dot_out[0];
      end else if (cnt_q < DOT_LAST) begin
        shift_d = {shift_q[7:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
        dot_out = decode_dot(de_q, cur_q, ul_q, attr_q, shift_d[8],
                             blink_enable, frame_cnt_q[BLINK_BIT], frame_cnt_q[CURSOR_BIT]);
        video_d     = dot_out[1];
        intensity_d = dot_out[0];
      end else begin
        cnt_d       = DOT_IDLE;
        video_d     = 1'b0;
        intensity_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q     <= 1'b0;
      frame_cnt_q <= 5'd0;
      shift_q     <= 9'd0;
      cnt_q       <= DOT_IDLE;
      attr_q      <= 8'd0;
      cur_q       <= 1'b0;
      ul_q        <= 1'b0;
      de_q        <= 1'b0;
      video_q     <= 1'b0;
      intensity_q <= 1'b0;
    end else begin
      vsync_q     <= vsync_d;
      frame_cnt_q <= frame_cnt_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      attr_q      <= attr_d;
      cur_q       <= cur_d;
      ul_q        <= ul_d;
      de_q        <= de_d;
      video_q     <= video_d;
      intensity_q <= intensity_d;
    end
  end

  assign video     = video_q;
  assign intensity = intensity_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mda_pixel_serializer.sv
// Directed bench for mda_pixel_serializer: each cell's 9 dots are compared
// against hand-computed video/intensity patterns (dot 0 in the MSB).
module tb_mda_pixel_serializer;

  logic       clk;
  logic       reset_n;
  logic       dot_en;
  logic       load;
  logic [7:0] char_row;
  logic [7:0] char_code;
  logic [7:0] attr;
  logic       cursor;
  logic       underline_row;
  logic       display_enable;
  logic       blink_enable;
  logic       vsync;
  logic       video;
  logic       intensity;
  logic [4:0] frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mda_pixel_serializer #(.BLINK_BIT(4), .CURSOR_BIT(3)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .dot_en        (dot_en),
    .load          (load),
    .char_row      (char_row),
    .char_code     (char_code),
    .attr          (attr),
    .cursor        (cursor),
    .underline_row (underline_row),
    .display_enable(display_enable),
    .blink_enable  (blink_enable),
    .vsync         (vsync),
    .video         (video),
    .intensity     (intensity),
    .frame_cnt     (frame_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one load at a negedge, then compares the 9 dots plus one idle dot.
  task automatic run_cell(input string tag, input logic [7:0] row, input logic [7:0] code,
                          input logic [7:0] a, input logic cur, input logic ul,
                          input logic de, input logic [8:0] exp_v, input logic [8:0] exp_i);
    logic [8:0] got_v;
    logic [8:0] got_i;
    @(negedge clk);
    char_row = row; char_code = code; attr = a; cursor = cur;
    underline_row = ul; display_enable = de; load = 1'b1; dot_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      load = 1'b0;
      got_v[8-i] = video;
      got_i[8-i] = intensity;
    end
    check({tag, "_video"}, {23'd0, got_v}, {23'd0, exp_v});
    check({tag, "_int"}, {23'd0, got_i}, {23'd0, exp_i});
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, video, intensity}, 32'd0);
  endtask

  task automatic pulse_vsync(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); vsync = 1'b1;
      @(negedge clk); vsync = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0; dot_en = 1'b0; load = 1'b0; char_row = 8'h00; char_code = 8'h00;
    attr = 8'h00; cursor = 1'b0; underline_row = 1'b0; display_enable = 1'b1;
    blink_enable = 1'b0; vsync = 1'b0;
    #12;
    check("reset_out", {30'd0, video, intensity}, 32'd0);
    check("reset_frame", {27'd0, frame_cnt}, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    // idle after reset: dot_en alone produces nothing
    @(negedge clk); dot_en = 1'b1;
    @(negedge clk); @(negedge clk);
    check("idle_after_reset", {30'd0, video, intensity}, 32'd0);

    run_cell("normal",      8'hA5, 8'h41, 8'h07, 1'b0, 1'b0, 1'b1, 9'b101001010, 9'b000000000);
    run_cell("lgfx_bright", 8'h81, 8'hC4, 8'h0F, 1'b0, 1'b0, 1'b1, 9'b100000011, 9'b100000011);
    run_cell("nolgfx",      8'h81, 8'h41, 8'h0F, 1'b0, 1'b0, 1'b1, 9'b100000010, 9'b100000010);
    run_cell("lgfx_edge",   8'h01, 8'hDF, 8'h07, 1'b0, 1'b0, 1'b1, 9'b000000011, 9'b000000000);
    run_cell("reverse",     8'hF0, 8'h41, 8'h70, 1'b0, 1'b0, 1'b1, 9'b000011111, 9'b000000000);
    run_cell("rev_bright",  8'hF0, 8'h41, 8'hF0, 1'b0, 1'b0, 1'b1, 9'b000011111, 9'b000011111);
    run_cell("invisible",   8'hFF, 8'h41, 8'h00, 1'b0, 1'b0, 1'b1, 9'b000000000, 9'b000000000);
    run_cell("underline",   8'h00, 8'h41, 8'h01, 1'b0, 1'b1, 1'b1, 9'b111111111, 9'b000000000);
    run_cell("ul_not_blue", 8'h00, 8'h41, 8'h07, 1'b0, 1'b1, 1'b1, 9'b000000000, 9'b000000000);
    run_cell("blanked",     8'hFF, 8'h41, 8'h07, 1'b0, 1'b0, 1'b0, 9'b000000000, 9'b000000000);

    // blink
    blink_enable = 1'b1;
    run_cell("blink_f0",    8'hFF, 8'h41, 8'h87, 1'b0, 1'b0, 1'b1, 9'b111111110, 9'b000000000);
    pulse_vsync(16);
    @(negedge clk);
    check("frame_16", {27'd0, frame_cnt}, 32'd16);
    run_cell("blink_f16",   8'hFF, 8'h41, 8'h87, 1'b0, 1'b0, 1'b1, 9'b000000000, 9'b000000000);
    blink_enable = 1'b0;
    run_cell("noblink_f16", 8'hFF, 8'h41, 8'h87, 1'b0, 1'b0, 1'b1, 9'b111111110, 9'b000000000);
    blink_enable = 1'b1;
    pulse_vsync(16);
    @(negedge clk);
    check("frame_wrap", {27'd0, frame_cnt}, 32'd0);
    run_cell("blink_f32",   8'hFF, 8'h41, 8'h87, 1'b0, 1'b0, 1'b1, 9'b111111110, 9'b000000000);
    blink_enable = 1'b0;

    // cursor
    run_cell("cursor_off",  8'h00, 8'h41, 8'h0F, 1'b1, 1'b0, 1'b1, 9'b000000000, 9'b000000000);
    pulse_vsync(8);
    @(negedge clk);
    check("frame_8", {27'd0, frame_cnt}, 32'd8);
    run_cell("cursor_on",   8'h00, 8'h41, 8'h0F, 1'b1, 1'b0, 1'b1, 9'b111111111, 9'b111111111);
    run_cell("cursor_dim",  8'h00, 8'h41, 8'h07, 1'b1, 1'b0, 1'b1, 9'b111111111, 9'b000000000);

    // outputs hold while dot_en is low; load with dot_en low is ignored
    @(negedge clk);
    char_row = 8'hA5; attr = 8'h07; cursor = 1'b0; underline_row = 1'b0;
    char_code = 8'h41; load = 1'b1; dot_en = 1'b1;
    @(negedge clk);
    load = 1'b0; dot_en = 1'b0;
    check("hold_dot0", {31'd0, video}, 32'd1);
    char_row = 8'h00; load = 1'b1;
    @(negedge clk); @(negedge clk);
    check("hold_no_en", {31'd0, video}, 32'd1);
    load = 1'b0; dot_en = 1'b1;
    @(negedge clk);
    check("resume_dot1", {31'd0, video}, 32'd0);
    @(negedge clk);
    check("resume_dot2", {31'd0, video}, 32'd1);

    // early load after dot 3 of a solid cell
    @(negedge clk);
    char_row = 8'hFF; load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load = 1'b0;
    end
    check("early_dot3", {31'd0, video}, 32'd1);
    char_row = 8'h80; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("early_new_dot0", {31'd0, video}, 32'd1);
    @(negedge clk);
    check("early_new_dot1", {31'd0, video}, 32'd0);
    @(negedge clk);
    check("early_new_dot2", {31'd0, video}, 32'd0);

    // reset in the middle of a cell
    @(negedge clk);
    char_row = 8'hFF; attr = 8'h0F; load = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      load = 1'b0;
    end
    check("pre_reset_dot5", {30'd0, video, intensity}, 32'd3);
    reset_n = 1'b0;
    #1;
    check("mid_reset_out", {30'd0, video, intensity}, 32'd0);
    check("mid_reset_frame", {27'd0, frame_cnt}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("post_reset_idle", {30'd0, video, intensity}, 32'd0);
    run_cell("after_reset", 8'hA5, 8'h41, 8'h07, 1'b0, 1'b0, 1'b1, 9'b101001010, 9'b000000000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mda_pixel_serializer.md
Name: mda_pixel_serializer

Overview:
- Generates the MDA per-dot `video` and `intensity` bits that feed the MDA-to-VGA colour port.
- Each character cell, it takes the font row byte, the attribute byte, the character code and the cursor/underline qualifiers from the CRTC/fetch pipeline, then shifts out 9 dots.
- Applies MDA attribute rules: invisible, reverse, underline, blink, high intensity, cursor, and line-graphics 9th-column replication.
- Sits between the character/font fetch logic and the colour port.

Parameters:
- BLINK_BIT, 4, frame-counter bit used as the character blink phase (32-frame period).
- CURSOR_BIT, 3, frame-counter bit used as the cursor blink phase (16-frame period).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- dot_en  input  1  one-cycle dot-clock enable; all dot-domain state advances only when high
- load  input  1  start of a new character cell; sampled only when dot_en=1
- char_row  input  8  font row bits, MSB = leftmost dot
- char_code  input  8  character code, used for the 9th-column rule
- attr  input  8  MDA attribute byte
- cursor  input  1  this cell is under the cursor and on a cursor scanline
- underline_row  input  1  current scanline is the underline row
- display_enable  input  1  CRTC active-display qualifier for this cell
- blink_enable  input  1  mode-register blink enable
- vsync  input  1  vertical sync, level, clk domain
- video  output  1  dot on
- intensity  output  1  dot bright
- frame_cnt  output  5  blink frame counter, for debug and verification

Behaviour:
- Reset (asynchronous, reset_n=0): video=0, intensity=0, frame_cnt=0, dot counter=9 (idle), shift register=0, latched attribute/flags=0.
- Frame counter:
  - vsync is registered once; a rising edge (prev=0, cur=1) increments frame_cnt, mod 32.
  - The vsync edge is independent of dot_en.
  - blink_off = frame_cnt[BLINK_BIT]; cursor_on = frame_cnt[CURSOR_BIT].
- Cell load (dot_en=1 and load=1):
  - Latch attr, cursor, underline_row, display_enable and the line-graphics flag (char_code[7:5]==3'b110, i.e. 0xC0-0xDF).
  - Shift register (9 bits) = {char_row, ninth}, where ninth = char_row[0] if line-graphics else 0.
  - Dot counter = 0.
  - Dot 0 is output at this same clock edge (combinational from the new inputs), so latency is 1 clk from load to the registered output.
- Subsequent dot_en cycles without load:
  - Shift left, increment the counter, output dots 1..8.
  - When the counter reaches 8 and another dot_en arrives without load: counter=9 (idle), output video=0, intensity=0 until the next load.
- load always wins. A load arriving before dot 8 discards the remaining dots of the old cell.
- load with dot_en=0 is ignored.
- Outputs hold their value on cycles where dot_en=0.
- Per-dot decode, applied in priority order (a = latched attribute, d = current dot bit):
  1. display_enable=0 → video=0, intensity=0.
  2. cursor=1 and cursor_on=1 → video=1, intensity=a[3].
  3. a & 8'h77 == 8'h00 (invisible) → video=0, intensity=0.
  4. fg = d, OR 1 when underline_row=1 and a[2:0]==3'b001.
  5. If blink_enable=1, a[7]=1 and blink_off=1 → fg=0.
  6. Reverse (a & 8'h77 == 8'h70) → video=~fg, intensity = (blink_enable=0) & a[7] & ~fg.
  7. Normal → video=fg, intensity=fg & a[3].
- intensity is never 1 when video is 0.
- reset_n asserted mid-cell: outputs go to 0 immediately; after release the block stays idle until the next load.

Test Plan:
- Normal glyph: attr=0x07, char_row=0xA5, code=0x41, dot_en every cycle, load once → video 1,0,1,0,0,1,0,1,0, intensity all 0, then video=0 from dot 9 on.
- Line graphics plus intensity: attr=0x0F, char_row=0x81, code=0xC4 → video 1,0,0,0,0,0,0,1,1, intensity equals video. Same with code=0x41 → dot 8 = 0.
- Reverse/invisible/underline:
  - attr=0x70, row=0xF0 → video 0,0,0,0,1,1,1,1,1.
  - attr=0x00 → all 0.
  - attr=0x01 with underline_row=1, row=0x00 → all 9 dots video=1.
- Blink:
  - attr=0x87, row=0xFF, blink_enable=1; after 16 vsync edges (frame_cnt=16) → all dots 0; after 32 edges → visible again.
  - With blink_enable=0 the dots stay visible.
- Cursor: cursor=1, row=0x00, attr=0x0F → dots all 1 with intensity 1 when frame_cnt=8..15, all 0 when frame_cnt=0..7.
- Early load and reset: second load after dot 3 → new cell's dot 0 on the next clock. reset_n low during dot 5 → video=0, intensity=0 immediately, frame_cnt=0, and 0 persists until a load.
